// File: rtl/a2d_rr_sched.sv
// Round-robin conversion scheduler for the 8-channel A2D.
// Two SPI transactions per trigger; results land in per-channel registers.
module a2d_rr_sched #(
  parameter logic [2:0] CH_LFT   = 3'd0,
  parameter logic [2:0] CH_RGHT  = 3'd4,
  parameter logic [2:0] CH_STEER = 3'd5,
  parameter logic [2:0] CH_BATT  = 3'd6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nxt,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] steer_pot,
  output logic [11:0] batt,
  output logic        cnv_cmplt,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    CONV1,
    GAP,
    CONV2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic        pend_q, pend_d;
  logic        wrt_q, wrt_d;
  logic [15:0] cmd_q, cmd_d;
  logic [11:0] lft_q, lft_d;
  logic [11:0] rght_q, rght_d;
  logic [11:0] steer_q, steer_d;
  logic [11:0] batt_q, batt_d;
  logic        cmplt_q, cmplt_d;
  logic        busy_q, busy_d;
  logic [2:0]  chan;
  logic        unused_hi;

  // Upper nibble of the receive word carries no result bits
  assign unused_hi = ^rd_data[15:12];

  // Map the round-robin pointer onto the physical ADC channel
  always_comb begin
    chan = CH_LFT;
    unique case (ptr_q)
      2'd0: chan = CH_LFT;
      2'd1: chan = CH_RGHT;
      2'd2: chan = CH_STEER;
      2'd3: chan = CH_BATT;
    endcase
  end

  // Sequence the two transactions, capture results, latch late triggers
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    pend_d  = pend_q;
    wrt_d   = 1'b0;
    cmd_d   = cmd_q;
    lft_d   = lft_q;
    rght_d  = rght_q;
    steer_d = steer_q;
    batt_d  = batt_q;
    cmplt_d = 1'b0;
    if (nxt && state_q != IDLE) pend_d = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (nxt || pend_q) begin
          wrt_d   = 1'b1;
          cmd_d   = {2'b00, chan, 11'h000};
          pend_d  = 1'b0;
          state_d = CONV1;
        end
      end
      CONV1: begin
        if (done) state_d = GAP;
      end
      GAP: begin
        wrt_d   = 1'b1;
        state_d = CONV2;
      end
      CONV2: begin
        if (done) begin
          state_d = IDLE;
          cmplt_d = 1'b1;
          ptr_d   = ptr_q + 2'd1;
          unique case (ptr_q)
            2'd0: lft_d   = rd_data[11:0];
            2'd1: rght_d  = rd_data[11:0];
            2'd2: steer_d = rd_data[11:0];
            2'd3: batt_d  = rd_data[11:0];
          endcase
        end
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // Register state and every output
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      pend_q  <= 1'b0;
      wrt_q   <= 1'b0;
      cmd_q   <= 16'h0000;
      lft_q   <= 12'h000;
      rght_q  <= 12'h000;
      steer_q <= 12'h000;
      batt_q  <= 12'h000;
      cmplt_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      pend_q  <= pend_d;
      wrt_q   <= wrt_d;
      cmd_q   <= cmd_d;
      lft_q   <= lft_d;
      rght_q  <= rght_d;
      steer_q <= steer_d;
      batt_q  <= batt_d;
      cmplt_q <= cmplt_d;
      busy_q  <= busy_d;
    end
  end

  assign wrt       = wrt_q;
  assign cmd       = cmd_q;
  assign lft_ld    = lft_q;
  assign rght_ld   = rght_q;
  assign steer_pot = steer_q;
  assign batt      = batt_q;
  assign cnv_cmplt = cmplt_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_a2d_rr_sched.sv
// Directed bench for a2d_rr_sched.
// Bench acts as the SPI monarch, answering each wrt with a done pulse.
module tb_a2d_rr_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        nxt;
  logic        done;
  logic [15:0] rd_data;
  logic        wrt;
  logic [15:0] cmd;
  logic [11:0] lft_ld;
  logic [11:0] rght_ld;
  logic [11:0] steer_pot;
  logic [11:0] batt;
  logic        cnv_cmplt;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int wrt_cnt = 0;
  int cmplt_cnt = 0;
  int b2b = 0;
  logic wrt_prev = 1'b0;

  logic [15:0] rr_val [5] = '{16'h0356, 16'h0357, 16'h0200,
                              16'h0900, 16'h0123};
  logic [15:0] rr_cmd [5] = '{16'h0000, 16'h2000, 16'h2800,
                              16'h3000, 16'h0000};

  a2d_rr_sched dut (
    .clk       (clk),
    .rst       (rst),
    .nxt       (nxt),
    .done      (done),
    .rd_data   (rd_data),
    .wrt       (wrt),
    .cmd       (cmd),
    .lft_ld    (lft_ld),
    .rght_ld   (rght_ld),
    .steer_pot (steer_pot),
    .batt      (batt),
    .cnv_cmplt (cnv_cmplt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Count pulses mid-cycle, away from the active edge
  always @(negedge clk) begin
    if (wrt === 1'b1) wrt_cnt <= wrt_cnt + 1;
    if (cnv_cmplt === 1'b1) cmplt_cnt <= cmplt_cnt + 1;
    if (wrt === 1'b1 && wrt_prev === 1'b1) b2b <= b2b + 1;
    wrt_prev <= wrt;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_wrt(input string tag);
    int n = 0;
    while (wrt !== 1'b1 && n < 12) begin
      step();
      n++;
    end
    checks++;
    if (wrt !== 1'b1) begin
      failures++;
      $display("FAIL %s_wrt_timeout got=%b exp=1", tag, wrt);
    end
  endtask

  task automatic run_conv(input logic trig, input logic [15:0] d2,
                          output logic [15:0] c1,
                          output logic [15:0] c2);
    if (trig) begin
      nxt = 1'b1;
      step();
      nxt = 1'b0;
    end
    wait_wrt("conv_first");
    c1 = cmd;
    step();
    step();
    done = 1'b1;
    rd_data = 16'hFFFF;
    step();
    done = 1'b0;
    rd_data = 16'h0000;
    wait_wrt("conv_second");
    c2 = cmd;
    step();
    done = 1'b1;
    rd_data = d2;
    step();
    done = 1'b0;
    rd_data = 16'h0000;
  endtask

  task automatic test_reset();
    int base;
    rst = 1'b1;
    nxt = 1'b0;
    done = 1'b0;
    rd_data = 16'h0000;
    step();
    step();
    rst = 1'b0;
    base = wrt_cnt;
    repeat (10) step();
    checks++;
    if (wrt !== 1'b0) begin
      failures++;
      $display("FAIL reset_wrt got=%b exp=0", wrt);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy got=%b exp=0", busy);
    end
    checks++;
    if (cnv_cmplt !== 1'b0) begin
      failures++;
      $display("FAIL reset_cmplt got=%b exp=0", cnv_cmplt);
    end
    checks++;
    if (cmd !== 16'h0000) begin
      failures++;
      $display("FAIL reset_cmd got=%h exp=0000", cmd);
    end
    checks++;
    if ({lft_ld, rght_ld, steer_pot, batt} !== 48'h0) begin
      failures++;
      $display("FAIL reset_results got=%h %h %h %h exp=000",
               lft_ld, rght_ld, steer_pot, batt);
    end
    checks++;
    if (wrt_cnt - base !== 0) begin
      failures++;
      $display("FAIL reset_idle_wrts got=%0d exp=0", wrt_cnt - base);
    end
  endtask

  task automatic test_single();
    int base;
    int cbase;
    base = wrt_cnt;
    cbase = cmplt_cnt;
    nxt = 1'b1;
    step();
    nxt = 1'b0;
    checks++;
    if (wrt !== 1'b1 || busy !== 1'b1 || cmd !== 16'h0000) begin
      failures++;
      $display("FAIL single_start got=wrt%b busy%b cmd%h exp=1 1 0000",
               wrt, busy, cmd);
    end
    step();
    checks++;
    if (wrt !== 1'b0) begin
      failures++;
      $display("FAIL single_conv1_wrt got=%b exp=0", wrt);
    end
    step();
    done = 1'b1;
    rd_data = 16'hFFFF;
    step();
    done = 1'b0;
    rd_data = 16'h0000;
    checks++;
    if (wrt !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_gap got=wrt%b busy%b exp=0 1", wrt, busy);
    end
    step();
    checks++;
    if (wrt !== 1'b1 || cmd !== 16'h0000) begin
      failures++;
      $display("FAIL single_second got=wrt%b cmd%h exp=1 0000", wrt, cmd);
    end
    step();
    done = 1'b1;
    rd_data = 16'hF356;
    step();
    done = 1'b0;
    rd_data = 16'h0000;
    checks++;
    if (lft_ld !== 12'h356 || cnv_cmplt !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_result got=%h cmplt%b busy%b exp=356 1 0",
               lft_ld, cnv_cmplt, busy);
    end
    checks++;
    if ({rght_ld, steer_pot, batt} !== 36'h0) begin
      failures++;
      $display("FAIL single_others got=%h %h %h exp=000",
               rght_ld, steer_pot, batt);
    end
    step();
    step();
    checks++;
    if (wrt_cnt - base !== 2 || cmplt_cnt - cbase !== 1) begin
      failures++;
      $display("FAIL single_pulses got=wrt%0d cmplt%0d exp=2 1",
               wrt_cnt - base, cmplt_cnt - cbase);
    end
  endtask

  task automatic test_round_robin();
    logic [15:0] c1;
    logic [15:0] c2;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      run_conv(1'b1, rr_val[i], c1, c2);
      checks++;
      if (c1 !== rr_cmd[i] || c2 !== rr_cmd[i]) begin
        failures++;
        $display("FAIL rr_cmd%0d got=%h %h exp=%h", i, c1, c2, rr_cmd[i]);
      end
      checks++;
      if (cnv_cmplt !== 1'b1) begin
        failures++;
        $display("FAIL rr_cmplt%0d got=%b exp=1", i, cnv_cmplt);
      end
      step();
    end
    checks++;
    if (lft_ld !== 12'h123 || rght_ld !== 12'h357) begin
      failures++;
      $display("FAIL rr_final_lr got=%h %h exp=123 357", lft_ld, rght_ld);
    end
    checks++;
    if (steer_pot !== 12'h200 || batt !== 12'h900) begin
      failures++;
      $display("FAIL rr_final_sb got=%h %h exp=200 900", steer_pot, batt);
    end
  endtask

  task automatic test_busy_triggers();
    logic [15:0] c1;
    logic [15:0] c2;
    int base;
    rst = 1'b1;
    step();
    rst = 1'b0;
    base = wrt_cnt;
    nxt = 1'b1;
    step();
    nxt = 1'b0;
    repeat (3) begin
      step();
      nxt = 1'b1;
      step();
      nxt = 1'b0;
    end
    done = 1'b1;
    rd_data = 16'hFFFF;
    step();
    done = 1'b0;
    rd_data = 16'h0000;
    wait_wrt("busy_second");
    step();
    done = 1'b1;
    rd_data = 16'h0111;
    step();
    done = 1'b0;
    rd_data = 16'h0000;
    checks++;
    if (busy !== 1'b0 || wrt !== 1'b0 || lft_ld !== 12'h111) begin
      failures++;
      $display("FAIL busy_first_end got=busy%b wrt%b lft%h exp=0 0 111",
               busy, wrt, lft_ld);
    end
    step();
    checks++;
    if (wrt !== 1'b1 || cmd !== 16'h2000 || busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_pending_start got=wrt%b cmd%h busy%b exp=1 2000 1",
               wrt, cmd, busy);
    end
    run_conv(1'b0, 16'h0222, c1, c2);
    checks++;
    if (rght_ld !== 12'h222 || c2 !== 16'h2000) begin
      failures++;
      $display("FAIL busy_pending_result got=%h cmd%h exp=222 2000",
               rght_ld, c2);
    end
    repeat (8) step();
    checks++;
    if (wrt_cnt - base !== 4 || busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_total_wrts got=%0d busy%b exp=4 0",
               wrt_cnt - base, busy);
    end
  endtask

  task automatic test_spurious_done();
    int base;
    done = 1'b1;
    rd_data = 16'hFFFF;
    step();
    done = 1'b0;
    rd_data = 16'h0000;
    checks++;
    if (busy !== 1'b0 || wrt !== 1'b0 || cnv_cmplt !== 1'b0) begin
      failures++;
      $display("FAIL spur_idle got=busy%b wrt%b cmplt%b exp=0 0 0",
               busy, wrt, cnv_cmplt);
    end
    checks++;
    if (lft_ld !== 12'h111 || rght_ld !== 12'h222 || steer_pot !== 12'h000) begin
      failures++;
      $display("FAIL spur_idle_regs got=%h %h %h exp=111 222 000",
               lft_ld, rght_ld, steer_pot);
    end
    step();
    base = wrt_cnt;
    nxt = 1'b1;
    step();
    nxt = 1'b0;
    step();
    done = 1'b1;
    rd_data = 16'hFFFF;
    step();
    done = 1'b0;
    rd_data = 16'h0000;
    checks++;
    if (wrt !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL spur_gap_entry got=wrt%b busy%b exp=0 1", wrt, busy);
    end
    done = 1'b1;
    rd_data = 16'h0AAA;
    step();
    done = 1'b0;
    rd_data = 16'h0000;
    checks++;
    if (wrt !== 1'b1 || cnv_cmplt !== 1'b0 || steer_pot !== 12'h000) begin
      failures++;
      $display("FAIL spur_gap got=wrt%b cmplt%b steer%h exp=1 0 000",
               wrt, cnv_cmplt, steer_pot);
    end
    step();
    checks++;
    if (wrt !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL spur_conv2 got=wrt%b busy%b exp=0 1", wrt, busy);
    end
    done = 1'b1;
    rd_data = 16'h0345;
    step();
    done = 1'b0;
    rd_data = 16'h0000;
    checks++;
    if (steer_pot !== 12'h345 || cnv_cmplt !== 1'b1) begin
      failures++;
      $display("FAIL spur_result got=%h cmplt%b exp=345 1",
               steer_pot, cnv_cmplt);
    end
    step();
    step();
    checks++;
    if (wrt_cnt - base !== 2) begin
      failures++;
      $display("FAIL spur_wrts got=%0d exp=2", wrt_cnt - base);
    end
  endtask

  task automatic test_reset_conv2();
    nxt = 1'b1;
    step();
    nxt = 1'b0;
    step();
    done = 1'b1;
    rd_data = 16'hFFFF;
    step();
    done = 1'b0;
    rd_data = 16'h0000;
    wait_wrt("rst_second");
    nxt = 1'b1;
    step();
    nxt = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || wrt !== 1'b0 || cmd !== 16'h0000) begin
      failures++;
      $display("FAIL rst_state got=busy%b wrt%b cmd%h exp=0 0 0000",
               busy, wrt, cmd);
    end
    checks++;
    if ({lft_ld, rght_ld, steer_pot, batt} !== 48'h0) begin
      failures++;
      $display("FAIL rst_regs got=%h %h %h %h exp=000",
               lft_ld, rght_ld, steer_pot, batt);
    end
    done = 1'b1;
    rd_data = 16'h0ABC;
    step();
    done = 1'b0;
    rd_data = 16'h0000;
    checks++;
    if (cnv_cmplt !== 1'b0 || batt !== 12'h000 || lft_ld !== 12'h000) begin
      failures++;
      $display("FAIL rst_late_done got=cmplt%b batt%h lft%h exp=0 000 000",
               cnv_cmplt, batt, lft_ld);
    end
    checks++;
    if (wrt !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_pending_clear got=wrt%b busy%b exp=0 0", wrt, busy);
    end
    step();
    nxt = 1'b1;
    step();
    nxt = 1'b0;
    checks++;
    if (wrt !== 1'b1 || cmd !== 16'h0000) begin
      failures++;
      $display("FAIL rst_next_cmd got=wrt%b cmd%h exp=1 0000", wrt, cmd);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] c1;
    logic [15:0] c2;
    step();
    done = 1'b1;
    rd_data = 16'hFFFF;
    step();
    done = 1'b0;
    rd_data = 16'h0000;
    wait_wrt("b2b_second");
    step();
    done = 1'b1;
    nxt = 1'b1;
    rd_data = 16'h0777;
    step();
    done = 1'b0;
    nxt = 1'b0;
    rd_data = 16'h0000;
    checks++;
    if (lft_ld !== 12'h777 || busy !== 1'b0 || wrt !== 1'b0) begin
      failures++;
      $display("FAIL b2b_end got=lft%h busy%b wrt%b exp=777 0 0",
               lft_ld, busy, wrt);
    end
    step();
    checks++;
    if (wrt !== 1'b1 || cmd !== 16'h2000) begin
      failures++;
      $display("FAIL b2b_edge_trigger got=wrt%b cmd%h exp=1 2000", wrt, cmd);
    end
    run_conv(1'b0, 16'h0888, c1, c2);
    checks++;
    if (rght_ld !== 12'h888) begin
      failures++;
      $display("FAIL b2b_result got=%h exp=888", rght_ld);
    end
    repeat (3) step();
    checks++;
    if (b2b !== 0) begin
      failures++;
      $display("FAIL b2b_wrt_adjacent got=%0d exp=0", b2b);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_busy_triggers();
    test_spurious_done();
    test_reset_conv2();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
